sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
Synchronous single-clock FIFO that buffers a data-word stream and presents each word on a registered output, for the 4-bit register stage to consume. It decouples a bursty producer from the register stage. Read and write use a per-cycle enable handshake, and the FIFO reports full/empty/occupancy. Read data has one-cycle latency, matching the register-stage timing used throughout the datapath.

Parameters:
WIDTH, 4, data word width in bits
DEPTH, 8, number of entries; must be a power of 2, and at least 2
CW, $clog2(DEPTH)+1, width of the count output (derived localparam, not overridable)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset; synchronous, active-high
wr_en  input  1  write request for the current cycle
din  input  WIDTH  write data, sampled with wr_en
rd_en  input  1  read request for the current cycle
dout  output  WIDTH  registered read data
full  output  1  asserted when count == DEPTH
empty  output  1  asserted when count == 0
count  output  CW  current number of stored words, 0..DEPTH

Behaviour:
- Reset: on a rising edge with rst=1, write pointer=0, read pointer=0, count=0, dout=0, empty=1, full=0. Memory contents are not cleared and are never observable after reset. rst overrides wr_en and rd_en in the same cycle.
- Reset mid-operation discards all stored words. The first read after reset returns the first word written after reset.
- Accepted write: wr_en=1 and (full=0, or rd_en=1 in the same cycle). The memory at the write pointer takes din, and the write pointer increments modulo DEPTH.
- Accepted read: rd_en=1 and empty=0. dout takes the word at the read pointer on the same edge, so it is valid in the following cycle (1-cycle latency). The read pointer increments modulo DEPTH.
- Ignored requests:
  - Write while full with no read: no state change; the stored data is not corrupted.
  - Read while empty: ignored; dout holds its previous value.
- dout holds its value in every cycle without an accepted read.
- Simultaneous rd_en and wr_en:
  - When full: both are accepted; count stays at DEPTH.
  - When empty: only the write is accepted; count becomes 1, dout is unchanged, and there is no bypass.
  - Otherwise: both are accepted; count is unchanged.
- count update: count+1 on write-only, count-1 on read-only, unchanged otherwise. full and empty are registered, derived from the next count, and valid in the same cycle as count.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are decided from count, never from pointer equality alone.

Optional Feature:
Macro: SYNC_FIFO_ERR_FLAGS_EN

Defined:
- Adds two output ports, overflow and underflow, each 1 bit.
- overflow is set on the edge after a write attempt with full=1 and rd_en=0.
- underflow is set on the edge after a read attempt with empty=1.
- Both flags are sticky and are cleared only by rst (reset value 0).

Not defined:
- The ports do not exist and no flag logic is generated.
- Ignored requests are silently dropped as described in Behaviour.

Test Plan:
All scenarios use WIDTH=4, DEPTH=8.
- Fill/drain: after reset, write 0..7 on 8 consecutive cycles -> count=8 and full=1 after the 8th edge. Then rd_en for 8 cycles -> dout=0..7, each one cycle after its rd_en; empty=1 and count=0 at the end.
- Overflow: with the FIFO full, write 4'hF -> count stays 8. Drain -> dout reads 0..7 and 4'hF never appears. With SYNC_FIFO_ERR_FLAGS_EN defined, overflow=1 and stays 1 until rst.
- Underflow: from reset, rd_en=1 for 2 cycles -> dout stays 0, count stays 0, empty stays 1. With the macro defined, underflow=1.
- Simultaneous: full with 0..7, then one cycle of rd_en=1, wr_en=1, din=4'hA -> count stays 8 and dout=0 next cycle. Drain -> dout reads 1..7 then A. From empty, rd_en=wr_en=1, din=4'h3 -> count=1, dout unchanged; next read returns 3.
- Wrap-around: write 5, read 5, write 8 words 8..F -> full=1. Read 8 -> dout=8..F in order; empty=1 at the end.
- Reset mid-operation: write 3 words, assert rst for 1 cycle while wr_en=1 and rd_en=1 -> count=0, empty=1, dout=0. Write 4'h6 then read -> dout=6.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data (one-cycle read latency).
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow output flags.
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: wr_en/rd_en are per-cycle requests with no ready return path.
  // A write is taken when not full, or when full with a same-cycle read.
  // A read is taken when not empty. The producer/consumer watch full/empty.
  logic             wr_acc;
  logic             rd_acc;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign wr_acc = wr_en && (!full_q || rd_en);
  assign rd_acc = rd_en && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dout_d   = mem_q[rd_ptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Flags come from the next count so they line up with count itself.
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == CW'(0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is not reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = dout_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  || (wr_en && full_q && !rd_en);
    underflow_d = underflow_q || (rd_en && empty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed scenarios plus random traffic against a queue model.
// Flag checks are compiled in when SYNC_FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo;
  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
  logic             exp_ovf;
  logic             exp_udf;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_dout;

  always #5 clk = ~clk;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .din   (din),
    .rd_en (rd_en),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  // Driver: apply one cycle of inputs, advance the model at the edge, sample 1ns later.
  task automatic cycle(input logic w, input logic [WIDTH-1:0] d, input logic r,
                       input logic rs = 1'b0);
    bit rd_ok;
    bit wr_ok;
    wr_en = w;
    din   = d;
    rd_en = r;
    rst   = rs;
    @(posedge clk);
    if (rs) begin
      exp_q.delete();
      exp_dout = '0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
`endif
    end else begin
      rd_ok = r && (exp_q.size() != 0);
      wr_ok = w && ((exp_q.size() < DEPTH) || r);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      if (w && !r && exp_q.size() == DEPTH) exp_ovf = 1'b1;
      if (r && exp_q.size() == 0) exp_udf = 1'b1;
`endif
      if (rd_ok) exp_dout = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(d);
    end
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b1, 4'h9, 1'b1, 1'b1);
    checks++; if (dout !== 4'h0) begin errors++; $display("FAIL reset_dout got %h exp 0", dout); end
    checks++; if (count !== CW'(0)) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags got %b%b exp 00", overflow, underflow);
    end
`endif
  endtask

  task automatic test_fill_drain();
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, WIDTH'(i), 1'b0);
      checks++; if (count !== CW'(i + 1)) begin errors++; $display("FAIL fill_count i=%0d got %0d exp %0d", i, count, i + 1); end
      checks++; if (full !== (i == DEPTH - 1)) begin errors++; $display("FAIL fill_full i=%0d got %b exp %b", i, full, i == DEPTH - 1); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty i=%0d got %b exp 0", i, empty); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1);
      checks++; if (dout !== WIDTH'(i)) begin errors++; $display("FAIL drain_dout i=%0d got %h exp %h", i, dout, WIDTH'(i)); end
      checks++; if (count !== CW'(DEPTH - 1 - i)) begin errors++; $display("FAIL drain_count i=%0d got %0d exp %0d", i, count, DEPTH - 1 - i); end
    end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL drain_flags got e=%b f=%b exp e=1 f=0", empty, full); end
  endtask

  task automatic test_overflow();
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(i), 1'b0);
    cycle(1'b1, 4'hF, 1'b0);
    checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_count got %0d exp %0d", count, DEPTH); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", full); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
`endif
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1);
      checks++; if (dout !== WIDTH'(i)) begin errors++; $display("FAIL ovf_drain i=%0d got %h exp %h", i, dout, WIDTH'(i)); end
    end
    cycle(1'b0, '0, 1'b0);
    checks++; if (empty !== 1'b1 || dout !== WIDTH'(DEPTH - 1)) begin
      errors++; $display("FAIL ovf_after got e=%b dout=%h exp e=1 dout=7", empty, dout);
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks++; if (overflow !== 1'b1 || underflow !== 1'b0) begin
      errors++; $display("FAIL ovf_sticky got %b%b exp 10", overflow, underflow);
    end
`endif
  endtask

  task automatic test_underflow();
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, '0, 1'b1);
      checks++; if (dout !== 4'h0) begin errors++; $display("FAIL udf_dout i=%0d got %h exp 0", i, dout); end
      checks++; if (count !== CW'(0) || empty !== 1'b1) begin
        errors++; $display("FAIL udf_state i=%0d got count=%0d e=%b exp count=0 e=1", i, count, empty);
      end
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks++; if (underflow !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL udf_flag got %b%b exp 01", overflow, underflow);
    end
`endif
  endtask

  task automatic test_simultaneous();
    logic [WIDTH-1:0] seq [DEPTH];
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(i), 1'b0);
    cycle(1'b1, 4'hA, 1'b1);
    checks++; if (count !== CW'(DEPTH) || full !== 1'b1) begin
      errors++; $display("FAIL sim_full_count got %0d f=%b exp %0d f=1", count, full, DEPTH);
    end
    checks++; if (dout !== 4'h0) begin errors++; $display("FAIL sim_full_dout got %h exp 0", dout); end
    for (int i = 0; i < DEPTH; i++) seq[i] = (i < DEPTH - 1) ? WIDTH'(i + 1) : 4'hA;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1);
      checks++; if (dout !== seq[i]) begin errors++; $display("FAIL sim_drain i=%0d got %h exp %h", i, dout, seq[i]); end
    end
    cycle(1'b1, 4'h3, 1'b1);
    checks++; if (count !== CW'(1) || empty !== 1'b0) begin
      errors++; $display("FAIL sim_empty_count got %0d e=%b exp 1 e=0", count, empty);
    end
    checks++; if (dout !== 4'hA) begin errors++; $display("FAIL sim_empty_dout got %h exp a", dout); end
    cycle(1'b0, '0, 1'b1);
    checks++; if (dout !== 4'h3) begin errors++; $display("FAIL sim_empty_read got %h exp 3", dout); end
  endtask

  task automatic test_wrap();
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'(i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b1);
      checks++; if (dout !== WIDTH'(i)) begin errors++; $display("FAIL wrap_pre i=%0d got %h exp %h", i, dout, WIDTH'(i)); end
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(8 + i), 1'b0);
    checks++; if (full !== 1'b1 || count !== CW'(DEPTH)) begin
      errors++; $display("FAIL wrap_full got f=%b count=%0d exp f=1 count=%0d", full, count, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1);
      checks++; if (dout !== WIDTH'(8 + i)) begin errors++; $display("FAIL wrap_read i=%0d got %h exp %h", i, dout, WIDTH'(8 + i)); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", empty); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(i + 1), 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 4'h5, 1'b1, 1'b1);
    checks++; if (count !== CW'(0) || empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL rstmid_state got count=%0d e=%b f=%b exp 0 1 0", count, empty, full);
    end
    checks++; if (dout !== 4'h0) begin errors++; $display("FAIL rstmid_dout got %h exp 0", dout); end
    cycle(1'b1, 4'h6, 1'b0);
    cycle(1'b0, '0, 1'b1);
    checks++; if (dout !== 4'h6) begin errors++; $display("FAIL rstmid_read got %h exp 6", dout); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %b exp 1", empty); end
  endtask

  task automatic test_random();
    logic w, r, rs;
    logic [WIDTH-1:0] d;
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int n = 0; n < 600; n++) begin
      w  = ($urandom_range(0, 99) < 60);
      r  = ($urandom_range(0, 99) < 45 + ((n / 100) % 2) * 20);
      rs = ($urandom_range(0, 99) == 0);
      d  = WIDTH'($urandom);
      cycle(w, d, r, rs);
      checks++; if (dout !== exp_dout) begin errors++; $display("FAIL rand_dout n=%0d got %h exp %h", n, dout, exp_dout); end
      checks++; if (count !== CW'(exp_q.size())) begin errors++; $display("FAIL rand_count n=%0d got %0d exp %0d", n, count, exp_q.size()); end
      checks++; if (full !== (exp_q.size() == DEPTH) || empty !== (exp_q.size() == 0)) begin
        errors++; $display("FAIL rand_flags n=%0d got f=%b e=%b exp size %0d", n, full, empty, exp_q.size());
      end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      checks++; if (overflow !== exp_ovf || underflow !== exp_udf) begin
        errors++; $display("FAIL rand_err n=%0d got %b%b exp %b%b", n, overflow, underflow, exp_ovf, exp_udf);
      end
`endif
    end
  endtask

  initial begin
    rst      = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    din      = '0;
    exp_dout = '0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
`endif
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
